// File: rtl/song_sequencer.sv
// Top-level sequencer for the note-highway datapath. It sweeps the background
// image, then loops over beats: redraw the 12 note boxes, wait, score, and shift.
module song_sequencer #(
    parameter int CYCLES_PER_BEAT = 12500000,
    parameter int SONG_BEATS      = 112,
    parameter int GRID_W          = 240,
    parameter int GRID_H          = 180,
    parameter int BOX_W           = 30,
    parameter int BOX_H           = 60,
    parameter int PIPE_LAT        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        shiftSong,
    output logic        changeScore,
    output logic        addScore,
    output logic        loadDefault,
    output logic        writeDefault,
    output logic [15:0] gridCounter,
    output logic [3:0]  boxCounter,
    output logic [14:0] pixelCount,
    output logic [14:0] memAddressPixelCount,
    output logic        loadX,
    output logic        loadY,
    output logic        writeToScreen,
    output logic        songDone,
    output logic        plot
);
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] DEF       = 4'd1;
    localparam logic [3:0] DEF_DRAIN = 4'd2;
    localparam logic [3:0] DRAW      = 4'd3;
    localparam logic [3:0] DRAIN     = 4'd4;
    localparam logic [3:0] WAIT      = 4'd5;
    localparam logic [3:0] SCORE     = 4'd6;
    localparam logic [3:0] ADD       = 4'd7;
    localparam logic [3:0] SHIFT     = 4'd8;
    localparam logic [3:0] DONE      = 4'd9;

    localparam int BTW = $clog2(CYCLES_PER_BEAT + 1);
    localparam int SNW = $clog2(SONG_BEATS + 1);
    localparam int DW  = $clog2(PIPE_LAT + 4);

    localparam logic [7:0]     GX_LAST   = 8'(GRID_W - 1);
    localparam logic [7:0]     GY_LAST   = 8'(GRID_H - 1);
    localparam logic [7:0]     BX_LAST   = 8'(BOX_W - 1);
    localparam logic [6:0]     BY_LAST   = 7'(BOX_H - 1);
    localparam logic [DW-1:0]  DEF_LAST  = DW'(2);
    localparam logic [DW-1:0]  BOX_LAST  = DW'(PIPE_LAT);
    localparam logic [BTW-1:0] BEAT_LAST = BTW'(CYCLES_PER_BEAT - 1);
    localparam logic [SNW-1:0] SONG_LAST = SNW'(SONG_BEATS - 1);

    logic [3:0]          state;
    logic [7:0]          gridX, gridY, boxX;
    logic [6:0]          boxY;
    logic [14:0]         memAddr;
    logic [3:0]          box;
    logic [DW-1:0]       drainCnt;
    logic [BTW-1:0]      beatCnt;
    logic [SNW-1:0]      beatNum;
    logic [2:0]          defDly;
    logic [PIPE_LAT-1:0] boxDly;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gridX    <= '0;
            gridY    <= '0;
            boxX     <= '0;
            boxY     <= '0;
            memAddr  <= '0;
            box      <= '0;
            drainCnt <= '0;
            beatCnt  <= '0;
            beatNum  <= '0;
            defDly   <= '0;
            boxDly   <= '0;
        end else begin
            // Valid delay lines model the datapath latency behind each issued pixel.
            defDly <= {defDly[1:0], state == DEF};
            boxDly <= (boxDly << 1) | PIPE_LAT'(state == DRAW);
            case (state)
                IDLE: if (start) begin
                    state   <= DEF;
                    beatNum <= '0;
                end
                DEF: begin
                    if (gridY == GY_LAST) begin
                        gridY <= '0;
                        if (gridX == GX_LAST) begin
                            gridX    <= '0;
                            drainCnt <= '0;
                            state    <= DEF_DRAIN;
                        end else begin
                            gridX <= gridX + 8'd1;
                        end
                    end else begin
                        gridY <= gridY + 8'd1;
                    end
                end
                DEF_DRAIN: begin
                    if (drainCnt == DEF_LAST) begin
                        drainCnt <= '0;
                        box      <= 4'd1;
                        state    <= DRAW;
                    end else begin
                        drainCnt <= drainCnt + DW'(1);
                    end
                end
                DRAW: begin
                    // Sprite address is the issue-order index, so it just counts.
                    memAddr <= memAddr + 15'd1;
                    if (boxY == BY_LAST) begin
                        boxY <= '0;
                        if (boxX == BX_LAST) begin
                            boxX     <= '0;
                            memAddr  <= '0;
                            drainCnt <= '0;
                            state    <= DRAIN;
                        end else begin
                            boxX <= boxX + 8'd1;
                        end
                    end else begin
                        boxY <= boxY + 7'd1;
                    end
                end
                DRAIN: begin
                    if (drainCnt == BOX_LAST) begin
                        drainCnt <= '0;
                        if (box == 4'd12) begin
                            box   <= '0;
                            state <= WAIT;
                        end else begin
                            box   <= box + 4'd1;
                            state <= DRAW;
                        end
                    end else begin
                        drainCnt <= drainCnt + DW'(1);
                    end
                end
                WAIT: begin
                    if (beatCnt == BEAT_LAST) begin
                        beatCnt <= '0;
                        state   <= SCORE;
                    end else begin
                        beatCnt <= beatCnt + BTW'(1);
                    end
                end
                SCORE: state <= ADD;
                ADD:   state <= SHIFT;
                SHIFT: begin
                    beatNum <= beatNum + SNW'(1);
                    if (beatNum == SONG_LAST) begin
                        state <= DONE;
                    end else begin
                        box   <= 4'd1;
                        state <= DRAW;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy                 = state != IDLE;
    assign shiftSong            = state == SHIFT;
    assign changeScore          = state == SCORE;
    assign addScore             = state == ADD;
    assign songDone             = state == DONE;
    assign loadX                = state == DRAW;
    assign loadY                = state == DRAW;
    assign loadDefault          = defDly[0];
    assign writeDefault         = defDly[1];
    assign writeToScreen        = boxDly[PIPE_LAT-1];
    assign plot                 = defDly[2] | boxDly[PIPE_LAT-1];
    assign gridCounter          = {gridX, gridY};
    assign boxCounter           = box;
    assign pixelCount           = {boxX, boxY};
    assign memAddressPixelCount = memAddr;
endmodule
